// File: rtl/hub75_scan_driver_if.sv
// Bundles the frame-buffer read port and the HUB75 panel pins of the scan driver.
// The driver uses the master modport; the frame buffer, the panel and the game logic use slave.
interface hub75_scan_driver_if #(
  parameter int COLS = 64,
  parameter int ROWS = 64
);
  logic                        en;
  logic [$clog2(ROWS)-1:0]     rd_row;
  logic [COLS-1:0]             rd_data;
  logic                        r1;
  logic                        r2;
  logic                        sclk;
  logic                        lat;
  logic                        oe_n;
  logic [$clog2(ROWS/2)-1:0]   addr;
  logic                        frame_done;

  modport master (
    input  en, rd_data,
    output rd_row, r1, r2, sclk, lat, oe_n, addr, frame_done
  );

  modport slave (
    output en, rd_data,
    input  rd_row, r1, r2, sclk, lat, oe_n, addr, frame_done
  );
endinterface

// File: rtl/hub75_scan_driver.sv
// Scans a COLSxROWS monochrome frame buffer out to a 1/(ROWS/2)-scan HUB75 panel.
// Each row pair is fetched, shifted MSB column first, latched, then shown for ON_CYCLES.
module hub75_scan_driver #(
  parameter int COLS      = 64,
  parameter int ROWS      = 64,
  parameter int ON_CYCLES = 256
) (
  input logic                 clk,
  input logic                 rst,
  hub75_scan_driver_if.master bus
);
  localparam int SCAN = ROWS / 2;
  localparam int RW   = $clog2(ROWS);
  localparam int AW   = $clog2(SCAN);
  localparam int CW   = $clog2(COLS);
  localparam int OW   = $clog2(ON_CYCLES + 1);

  typedef enum logic [2:0] {
    FETCH_A, FETCH_B, CAPT, SHIFT, LATCH, DISPLAY
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   col_reg, col_next;
  logic            phase_reg, phase_next;
  logic [OW-1:0]   on_reg, on_next;
  logic [COLS-1:0] top_sr_reg, top_sr_next;
  logic [COLS-1:0] bot_sr_reg, bot_sr_next;
  logic [RW-1:0]   rd_row_reg, rd_row_next;
  logic            r1_reg, r1_next;
  logic            r2_reg, r2_next;
  logic            sclk_reg, sclk_next;
  logic            lat_reg, lat_next;
  logic            oe_n_reg, oe_n_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic            frame_done_reg, frame_done_next;

  // Outputs are computed for the state being entered, so each registered
  // output lines up with state_reg in the following cycle.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    col_next        = col_reg;
    phase_next      = phase_reg;
    on_next         = on_reg;
    top_sr_next     = top_sr_reg;
    bot_sr_next     = bot_sr_reg;
    rd_row_next     = rd_row_reg;
    r1_next         = r1_reg;
    r2_next         = r2_reg;
    addr_next       = addr_reg;
    sclk_next       = 1'b0;
    lat_next        = 1'b0;
    oe_n_next       = 1'b1;
    frame_done_next = 1'b0;

    case (state_reg)
      FETCH_A: begin
        if (bus.en) begin
          state_next  = FETCH_B;
          rd_row_next = RW'(cnt_reg) + RW'(SCAN);
        end
      end
      FETCH_B: begin
        top_sr_next = bus.rd_data;
        state_next  = CAPT;
      end
      CAPT: begin
        // bot_sr is still loading, so the first lower bit comes straight from rd_data.
        bot_sr_next = bus.rd_data;
        col_next    = CW'(COLS - 1);
        phase_next  = 1'b0;
        r1_next     = top_sr_reg[COLS-1];
        r2_next     = bus.rd_data[COLS-1];
        state_next  = SHIFT;
      end
      SHIFT: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
          sclk_next  = 1'b1;
        end else if (col_reg == '0) begin
          phase_next = 1'b0;
          lat_next   = 1'b1;
          addr_next  = cnt_reg;
          state_next = LATCH;
        end else begin
          phase_next = 1'b0;
          col_next   = col_reg - CW'(1);
          r1_next    = top_sr_reg[col_reg - CW'(1)];
          r2_next    = bot_sr_reg[col_reg - CW'(1)];
        end
      end
      LATCH: begin
        on_next    = '0;
        oe_n_next  = 1'b0;
        state_next = DISPLAY;
      end
      DISPLAY: begin
        if (on_reg == OW'(ON_CYCLES - 1)) begin
          cnt_next        = (cnt_reg == AW'(SCAN - 1)) ? '0 : cnt_reg + AW'(1);
          frame_done_next = (cnt_reg == AW'(SCAN - 1));
          rd_row_next     = RW'(cnt_next);
          state_next      = FETCH_A;
        end else begin
          on_next   = on_reg + OW'(1);
          oe_n_next = 1'b0;
        end
      end
      default: state_next = FETCH_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH_A;
      cnt_reg        <= '0;
      col_reg        <= '0;
      phase_reg      <= 1'b0;
      on_reg         <= '0;
      top_sr_reg     <= '0;
      bot_sr_reg     <= '0;
      rd_row_reg     <= '0;
      r1_reg         <= 1'b0;
      r2_reg         <= 1'b0;
      sclk_reg       <= 1'b0;
      lat_reg        <= 1'b0;
      oe_n_reg       <= 1'b1;
      addr_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      col_reg        <= col_next;
      phase_reg      <= phase_next;
      on_reg         <= on_next;
      top_sr_reg     <= top_sr_next;
      bot_sr_reg     <= bot_sr_next;
      rd_row_reg     <= rd_row_next;
      r1_reg         <= r1_next;
      r2_reg         <= r2_next;
      sclk_reg       <= sclk_next;
      lat_reg        <= lat_next;
      oe_n_reg       <= oe_n_next;
      addr_reg       <= addr_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.rd_row     = rd_row_reg;
  assign bus.r1         = r1_reg;
  assign bus.r2         = r2_reg;
  assign bus.sclk       = sclk_reg;
  assign bus.lat        = lat_reg;
  assign bus.oe_n       = oe_n_reg;
  assign bus.addr       = addr_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: a registered-read frame buffer plus an event-level
// panel model that rebuilds each shifted row pair and checks it against the buffer.
module tb_hub75_scan_driver;
  localparam int COLS = 64;
  localparam int ROWS = 64;
  localparam int SCAN = ROWS / 2;
  localparam int ON_CYCLES = 256;
  localparam int ROW_PERIOD = 4 + 2 * COLS + ON_CYCLES;
  localparam int FRAME_PERIOD = SCAN * ROW_PERIOD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  logic [COLS-1:0] mem [ROWS];

  hub75_scan_driver_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  hub75_scan_driver #(.COLS(COLS), .ROWS(ROWS), .ON_CYCLES(ON_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) bus.rd_data <= mem[bus.rd_row];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < ROWS; i++) mem[i] = {$urandom, $urandom};
  endtask

  // ---------------- panel / scoreboard model ----------------
  bit rst_eff = 1'b1;
  int cyc = 0, row_edges = 0, total_edges = 0, total_lats = 0, total_fd = 0;
  int oe_run = 0, lat_cyc = 0, fd_cyc = 0, exp_cnt = 0;
  bit lat_valid = 1'b0, fd_valid = 1'b0;
  logic [COLS-1:0] top_cap = '0, bot_cap = '0;
  logic p_sclk = 1'b0, p_lat = 1'b0, p_oe = 1'b1;
  logic [4:0] p_addr = '0;

  always @(posedge clk) rst_eff = rst;

  always @(negedge clk) begin
    bit oe_rise;
    cyc++;
    if (rst_eff) begin
      check("reset_outputs",
            {bus.rd_row, bus.r1, bus.r2, bus.sclk, bus.lat, bus.oe_n, bus.addr, bus.frame_done},
            {6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0});
      row_edges = 0; oe_run = 0; exp_cnt = 0;
      lat_valid = 1'b0; fd_valid = 1'b0;
      top_cap = '0; bot_cap = '0;
    end else begin
      if (!bus.en) begin lat_valid = 1'b0; fd_valid = 1'b0; end
      if (bus.sclk && !p_sclk) begin
        top_cap = {top_cap[COLS-2:0], bus.r1};
        bot_cap = {bot_cap[COLS-2:0], bus.r2};
        row_edges++;
        total_edges++;
      end
      if (bus.sclk || bus.lat) check("dark_while_shifting", bus.oe_n, 1'b1);
      if (p_lat) check("lat_width", bus.lat, 1'b0);
      if (bus.addr != p_addr) check("addr_change_in_latch", {bus.lat, bus.oe_n}, 2'b11);
      if (bus.lat && !p_lat) begin
        total_lats++;
        check("row_edges", row_edges, COLS);
        check("r1_row", top_cap, mem[exp_cnt]);
        check("r2_row", bot_cap, mem[exp_cnt + SCAN]);
        check("addr_at_lat", bus.addr, exp_cnt);
        if (lat_valid) check("lat_period", cyc - lat_cyc, ROW_PERIOD);
        lat_cyc = cyc; lat_valid = 1'b1; row_edges = 0;
      end
      if (!bus.oe_n) oe_run++;
      oe_rise = bus.oe_n && !p_oe;
      if (oe_rise) begin
        check("oe_low_cycles", oe_run, ON_CYCLES);
        oe_run = 0;
        exp_cnt = (exp_cnt + 1) % SCAN;
      end
      if (oe_rise || bus.frame_done) begin
        check("frame_done", bus.frame_done, oe_rise && exp_cnt == 0);
        if (bus.frame_done) begin
          total_fd++;
          check("rd_row_after_frame", bus.rd_row, 0);
          if (fd_valid) check("frame_period", cyc - fd_cyc, FRAME_PERIOD);
          fd_cyc = cyc; fd_valid = 1'b1;
        end
      end
    end
    p_sclk = bus.sclk; p_lat = bus.lat; p_oe = bus.oe_n; p_addr = bus.addr;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input bit en_v, input int n);
    @(posedge clk); #1;
    rst = 1'b1; bus.en = en_v;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic check_release(input bit en_v);
    @(negedge clk); check("rel_rd_row_first", bus.rd_row, 0);
    @(negedge clk); check("rel_rd_row_second", bus.rd_row, en_v ? 32 : 0);
  endtask

  task automatic wait_lat(input string tag, input int budget);
    int start = total_lats;
    for (int i = 0; i < budget && total_lats == start; i++) @(negedge clk);
    check(tag, total_lats > start, 1'b1);
  endtask

  task automatic idle_check(input string tag);
    int e0 = total_edges, l0 = total_lats, lowc = 0;
    repeat (300) begin @(negedge clk); if (!bus.oe_n) lowc++; end
    check({tag, "_edges"}, total_edges - e0, 0);
    check({tag, "_lats"}, total_lats - l0, 0);
    check({tag, "_oe_low"}, lowc, 0);
  endtask

  initial begin
    int k, seen;
    bus.en = 1'b1;
    for (int i = 0; i < ROWS; i++) mem[i] = '0;

    // Reset held, then released on an all-zero buffer.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_release(1'b1);
    wait_lat("zero_row_timeout", 500);

    // Single-bit corner rows, then random frames refreshed on each frame_done.
    rand_mem();
    mem[0] = 64'h8000_0000_0000_0000;
    mem[32] = 64'h0000_0000_0000_0001;
    do_reset(1'b1, 2);
    check_release(1'b1);
    seen = 0;
    for (int i = 0; i < 2 * FRAME_PERIOD + 1000 && seen < 2; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin seen++; rand_mem(); end
    end
    check("frame_timeout", seen, 2);

    // Disabled from reset: nothing moves.
    do_reset(1'b0, 2);
    check_release(1'b0);
    idle_check("en_low");

    // Drop en mid-shift: row finishes, then the block halts at the next row pair.
    @(posedge clk); #1 bus.en = 1'b1;
    k = $urandom_range(5, 60);
    for (int i = 0; i < 500 && row_edges < k; i++) @(negedge clk);
    check("shift_reach_timeout", row_edges >= k, 1'b1);
    @(posedge clk); #1 bus.en = 1'b0;
    wait_lat("drop_lat", 300);
    repeat (300) @(negedge clk);
    check("halt_oe_done", oe_run, 0);
    idle_check("halted");
    check("halt_rd_row", bus.rd_row, 1);

    // Reset mid-shift at column 40, then at random columns.
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1 bus.en = 1'b1;
      k = (t == 0) ? (COLS - 1 - 40) : $urandom_range(1, 62);
      for (int i = 0; i < 1000 && row_edges != k; i++) @(negedge clk);
      check("rst_point_timeout", row_edges, k);
      rand_mem();
      do_reset(1'b1, 1);
      check_release(1'b1);
      wait_lat("restart_lat", 500);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
